// File: rtl/mem_pkg.sv
// Shared types and default sizes for the loadable stack memory.
//   mem_state_t : controller state (zeroing sweep, CPU service, program load)
//   DATA_W_DEF / ADDR_W_DEF : default word width and address width
package mem_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    LOAD
  } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage with one synchronous write port and one registered read port.
//   clk, rst          : clock, async active-high reset (clears only the read register)
//   we_i/waddr_i/wdata_i : write port, written at the rising edge when we_i=1
//   re_i/raddr_i      : read enable and address
//   rdata_o           : registered read data, updated only on enabled reads
module mem_array #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // No reset on the array itself so it can map onto RAM; the controller's sweep zeroes it.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/loadable_stack_memory.sv
// Data/program memory for the stack processor with a zeroing sweep after reset and a
// streaming program loader.
//   clk, rst                         : clock, async active-high reset
//   cpu_en/cpu_we/cpu_addr/cpu_wdata : CPU single access port, accepted while cpu_ready=1
//   cpu_ready, cpu_rdata, cpu_rvalid : CPU handshake and registered read data (latency 1)
//   ld_start/ld_base                 : begin a load at ld_base (sampled while idle)
//   ld_valid/ld_data/ld_last         : load word stream, accepted while ld_ready=1
//   ld_ready, ld_done, ld_err, ld_count : loader status
module loadable_stack_memory
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_err,
  output logic [ADDR_W:0]   ld_count
);

  localparam mem_state_t      ResetState = CLEAR_ON_RESET ? CLEAR : IDLE;
  localparam logic [ADDR_W-1:0] PtrMax   = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   CountMax = {1'b1, {ADDR_W{1'b0}}};

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [ADDR_W-1:0] ld_ptr_q, ld_ptr_d;
  logic [ADDR_W:0]   ld_count_q, ld_count_d;
  logic              ld_err_q, ld_err_d;
  logic              ld_done_q, ld_done_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;

  always_comb begin
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    ld_ptr_d     = ld_ptr_q;
    ld_count_d   = ld_count_q;
    ld_err_d     = ld_err_q;
    ld_done_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = '0;
    mem_wdata    = '0;
    mem_re       = 1'b0;

    // The state alone selects the write source, so the sources never collide.
    unique case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == PtrMax) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (cpu_en && cpu_we) begin
          mem_we    = 1'b1;
          mem_waddr = cpu_addr;
          mem_wdata = cpu_wdata;
        end
        if (cpu_en && !cpu_we) begin
          mem_re       = 1'b1;
          cpu_rvalid_d = 1'b1;
        end
        // A CPU access in the same cycle still completes; the load starts next cycle.
        if (ld_start) begin
          state_d    = LOAD;
          ld_ptr_d   = ld_base;
          ld_count_d = '0;
          ld_err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (ld_valid) begin
          mem_we    = 1'b1;
          mem_waddr = ld_ptr_q;
          mem_wdata = ld_data;
          if (ld_count_q != CountMax) begin
            ld_count_d = ld_count_q + (ADDR_W + 1)'(1);
          end
          if (ld_last) begin
            state_d   = IDLE;
            ld_done_d = 1'b1;
          end else if (ld_ptr_q == PtrMax) begin
            // Ran off the top of memory: stop rather than wrap onto low addresses.
            state_d   = IDLE;
            ld_done_d = 1'b1;
            ld_err_d  = 1'b1;
          end else begin
            ld_ptr_d = ld_ptr_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d = ResetState;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ResetState;
      clr_ptr_q    <= '0;
      ld_ptr_q     <= '0;
      ld_count_q   <= '0;
      ld_err_q     <= 1'b0;
      ld_done_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      ld_ptr_q     <= ld_ptr_d;
      ld_count_q   <= ld_count_d;
      ld_err_q     <= ld_err_d;
      ld_done_q    <= ld_done_d;
      cpu_rvalid_q <= cpu_rvalid_d;
    end
  end

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .re_i    (mem_re),
    .raddr_i (cpu_addr),
    .rdata_o (cpu_rdata)
  );

  assign cpu_ready  = (state_q == IDLE);
  assign ld_ready   = (state_q == LOAD);
  assign cpu_rvalid = cpu_rvalid_q;
  assign ld_done    = ld_done_q;
  assign ld_err     = ld_err_q;
  assign ld_count   = ld_count_q;

endmodule

// File: tb/tb_loadable_stack_memory.sv
module tb_loadable_stack_memory;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  localparam int MS_CLR  = 0;
  localparam int MS_IDLE = 1;
  localparam int MS_LOAD = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_en, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ready;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready, ld_done, ld_err;
  logic [AW:0]   ld_count;

  loadable_stack_memory #(
    .DATA_W         (DW),
    .ADDR_W         (AW),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_en     (cpu_en),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .ld_start   (ld_start),
    .ld_base    (ld_base),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .ld_done    (ld_done),
    .ld_err     (ld_err),
    .ld_count   (ld_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: abstract memory contents plus loader/controller status.
  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } exp_t;
  exp_t sb[$];

  int            m_state;
  int            m_clr_left;
  logic [DW-1:0] m_mem[DEPTH];
  int            m_ptr;
  int            m_count;
  bit            m_err;
  bit            m_done;
  logic [DW-1:0] m_rdata;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;  // the sweep will zero everything
    m_state    = MS_CLR;
    m_clr_left = DEPTH;
    m_ptr      = 0;
    m_count    = 0;
    m_err      = 1'b0;
    m_done     = 1'b0;
    m_rdata    = '0;
    sb.delete();
  endtask

  task automatic clr_in();
    cpu_en = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ld_start = 0; ld_base = '0; ld_valid = 0; ld_data = '0; ld_last = 0;
  endtask

  // Predict the effect of the currently driven inputs, cross one clock edge, then compare.
  task automatic tick();
    m_done = 1'b0;
    case (m_state)
      MS_CLR: begin
        m_clr_left--;
        if (m_clr_left == 0) m_state = MS_IDLE;
      end
      MS_IDLE: begin
        if (cpu_en && cpu_we) begin
          m_mem[cpu_addr] = cpu_wdata;
        end else if (cpu_en) begin
          sb.push_back('{d: m_mem[cpu_addr], c: cyc + 1});
          m_rdata = m_mem[cpu_addr];
        end
        if (ld_start) begin
          m_state = MS_LOAD;
          m_ptr   = ld_base;
          m_count = 0;
          m_err   = 1'b0;
        end
      end
      default: begin
        if (ld_valid) begin
          m_mem[m_ptr] = ld_data;
          if (m_count < DEPTH) m_count++;
          if (ld_last) begin
            m_state = MS_IDLE;
            m_done  = 1'b1;
          end else if (m_ptr == DEPTH - 1) begin
            m_state = MS_IDLE;
            m_done  = 1'b1;
            m_err   = 1'b1;
          end else begin
            m_ptr++;
          end
        end
      end
    endcase
    @(posedge clk);
    #1;
    chk("cpu_ready", cpu_ready, m_state == MS_IDLE);
    chk("ld_ready", ld_ready, m_state == MS_LOAD);
    chk("ld_done", ld_done, m_done);
    chk("ld_err", ld_err, m_err);
    chk("ld_count", ld_count, m_count);
    chk("cpu_rdata_hold", cpu_rdata, m_rdata);
  endtask

  task automatic cpu_op(input bit we, input int addr, input int data);
    cpu_en = 1; cpu_we = we; cpu_addr = AW'(addr); cpu_wdata = DW'(data);
    tick();
    clr_in();
  endtask

  task automatic start_load(input int base);
    ld_start = 1; ld_base = AW'(base);
    tick();
    clr_in();
  endtask

  task automatic word(input int data, input bit last);
    ld_valid = 1; ld_data = DW'(data); ld_last = last;
    tick();
    clr_in();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_sweep();
    for (int i = 0; i < 4 * DEPTH && m_state != MS_IDLE; i++) tick();
    chk("sweep_done", cpu_ready, 1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_ld_done", ld_done, 0);
    chk("rst_ld_err", ld_err, 0);
    chk("rst_ld_count", ld_count, 0);
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_ld_ready", ld_ready, 0);
  endtask

  // Reset asserted between clock edges; outputs must clear without waiting for an edge.
  task automatic mid_cycle_reset();
    #3;
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Scoreboard monitor: every read response must match the queued prediction in data and cycle.
  exp_t e;
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_rvalid) begin
        if (sb.size() == 0) begin
          chk("rvalid_unexpected", cpu_rvalid, 0);
        end else begin
          e = sb.pop_front();
          chk("rdata", cpu_rdata, e.d);
          chk("rvalid_cycle", cyc, e.c);
        end
      end else if (sb.size() > 0 && sb[0].c <= cyc) begin
        chk("rvalid_missing", cpu_rvalid, 1);
        e = sb.pop_front();
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clr_in();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst = 1'b0;

    // Sweep length, then a read of the top word.
    wait_sweep();
    cpu_op(0, 31, 0);
    idle(2);

    // Write then read the same address, a neighbour, and hold behaviour.
    cpu_op(1, 3, 8'hA5);
    cpu_op(0, 3, 0);
    idle(2);
    cpu_op(0, 4, 0);
    idle(2);

    // Load with a gap and ld_last on the fourth word.
    start_load(0);
    word(8'h9D, 0);
    word(8'h9D, 0);
    idle(2);
    word(8'h00, 0);
    word(8'hC7, 1);
    idle(1);
    for (int a = 0; a < 4; a++) cpu_op(0, a, 0);

    // Load running off the top of memory without ld_last.
    start_load(30);
    word(8'h11, 0);
    word(8'h22, 0);
    word(8'h33, 0);
    cpu_op(0, 30, 0);
    cpu_op(0, 31, 0);
    cpu_op(0, 0, 0);
    idle(1);

    // Reset in the middle of a load, then a full sweep and readback.
    start_load(5);
    word(8'h55, 0);
    word(8'h66, 0);
    mid_cycle_reset();
    wait_sweep();
    for (int a = 0; a < DEPTH; a++) cpu_op(0, a, 0);
    idle(1);

    // ld_start together with a CPU write; CPU read during LOAD is dropped.
    ld_start = 1; ld_base = AW'(10);
    cpu_en = 1; cpu_we = 1; cpu_addr = AW'(7); cpu_wdata = 8'h3C;
    tick();
    clr_in();
    cpu_op(0, 7, 0);
    word(8'h44, 1);
    cpu_op(0, 7, 0);
    cpu_op(0, 10, 0);
    idle(1);

    // Randomised traffic across CPU accesses and loads.
    for (int i = 0; i < 400; i++) begin
      cpu_en    = ($urandom_range(0, 9) < 7);
      cpu_we    = $urandom_range(0, 1);
      cpu_addr  = AW'($urandom_range(0, DEPTH - 1));
      cpu_wdata = DW'($urandom);
      ld_data   = DW'($urandom);
      if (m_state == MS_IDLE) begin
        ld_start = ($urandom_range(0, 15) == 0);
        ld_base  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(24, DEPTH - 1))
                                               : AW'($urandom_range(0, DEPTH - 1));
        ld_valid = $urandom_range(0, 1);
      end else begin
        ld_valid = ($urandom_range(0, 3) != 0);
        ld_last  = ($urandom_range(0, 7) == 0);
        ld_start = $urandom_range(0, 1);
        ld_base  = AW'($urandom_range(0, DEPTH - 1));
      end
      tick();
      clr_in();
    end
    if (m_state == MS_LOAD) word(8'hE1, 1);
    idle(1);
    for (int a = 0; a < DEPTH; a++) cpu_op(0, a, 0);
    idle(3);
    chk("scoreboard_drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/loadable_stack_memory.md
Name: loadable_stack_memory

Overview:
- Parametrised successor to the 32x8 data/program memory used by the stack processor.
- Generalised in data width and depth.
- Adds a clear-on-reset sweep, so no simulation-only initial contents are needed.
- Adds a streaming program-loader port that fills consecutive addresses from a base address.
- Sits between the CPU datapath (single access port) and the testbench/boot loader.

Parameters:
DATA_W, 8, word width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W words (localparam, not overridable)
CLEAR_ON_RESET, 1, 1 = run zeroing sweep after reset; 0 = go straight to IDLE, contents undefined

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
cpu_en  in  1  CPU access request, sampled when cpu_ready=1
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_ready  out  1  CPU port accepting (state==IDLE)
cpu_rdata  out  DATA_W  registered read data
cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid
ld_start  in  1  begin load, sampled in IDLE
ld_base  in  ADDR_W  first load address, captured with ld_start
ld_valid  in  1  load word valid
ld_data  in  DATA_W  load word
ld_last  in  1  marks final load word, qualified by ld_valid
ld_ready  out  1  loader accepting (state==LOAD)
ld_done  out  1  one-cycle pulse, load finished
ld_err  out  1  sticky, load hit top of memory without ld_last
ld_count  out  ADDR_W+1  words written by current/last load

Behaviour:
- Reset (async assert):
  - state = CLEAR if CLEAR_ON_RESET, else IDLE; clr_ptr = 0.
  - cpu_rdata = 0, cpu_rvalid = 0, ld_done = 0, ld_err = 0, ld_count = 0, load pointer = 0.
  - Assertion mid-load or mid-clear aborts immediately; the sweep reruns after release.
- CLEAR:
  - Writes 0 to mem[clr_ptr] each cycle and increments clr_ptr.
  - After writing DEPTH-1, goes to IDLE: exactly DEPTH cycles.
  - cpu_ready = 0, ld_ready = 0; ld_start is ignored.
- IDLE: cpu_ready = 1.
  - cpu_en & cpu_we: mem[cpu_addr] <= cpu_wdata at the edge.
  - cpu_en & !cpu_we: cpu_rdata <= mem[cpu_addr] and cpu_rvalid = 1 on the next cycle (latency 1).
  - Back-to-back reads are allowed, one per cycle.
  - cpu_rdata holds its last value when no read occurs.
  - Write then read of the same address on the next cycle returns the new data.
  - ld_start (same cycle as a CPU access is allowed): the CPU access completes; ptr <= ld_base, ld_count <= 0, ld_err <= 0; state -> LOAD.
- LOAD: ld_ready = 1, cpu_ready = 0; CPU requests are ignored, not queued.
  - Each ld_valid cycle: mem[ptr] <= ld_data, ptr++, ld_count++.
  - ld_valid & ld_last: final write, state -> IDLE, ld_done pulse on the next cycle.
  - ld_valid at ptr == DEPTH-1 without ld_last: write performed, state -> IDLE, ld_done pulse, ld_err = 1. The pointer never wraps.
  - ld_valid gaps (ld_valid = 0) are allowed indefinitely.
- Only one write source is active per cycle, selected by state; no arbitration is needed.
- ld_count saturates at DEPTH and is held until the next ld_start.

Decomposition:
- Package mem_pkg:
  - mem_state_t enum {CLEAR, IDLE, LOAD}
  - default width constants DATA_W_DEF=8, ADDR_W_DEF=5
- Sub-module mem_array: one write port, one registered read port, parametrised DATA_W/ADDR_W.
- Parent block contains the FSM, pointers and the write-source mux.

Test Plan:
- Release reset (defaults): cpu_ready low exactly 32 cycles then high; read addr 31 -> cpu_rdata=0x00 with cpu_rvalid for exactly one cycle, one cycle after the request.
- IDLE: write 0xA5 @3, read @3 next cycle -> 0xA5 with rvalid; read @4 -> 0x00; cpu_rdata holds 0xA5/0x00 while idle.
- ld_start base 0; stream 0x9D, 0x9D, 0x00, 0xC7 with a 2-cycle ld_valid gap, ld_last on 4th -> ld_done pulse, ld_count=4, ld_err=0; reads @0..3 return the stream.
- ld_start base 30; send 3 words, no last -> @30, @31 written, ld_err=1, ld_count=2, ld_ready low before third word; mem[0] unchanged.
- rst asserted mid-load (after 2 words) -> outputs zero the same cycle; after release, 32-cycle sweep, all addresses read 0x00.
- IDLE: ld_start with cpu write 0x3C @7 the same cycle -> mem[7]=0x3C, state LOAD next cycle; CPU read during LOAD produces no rvalid.
